branch_resolve_unit: RTL and testbench

ID-stage branch resolution unit that closes the loop with the fetch-side BTB/2-bit predictor. It carries each fetched instruction's prediction metadata through its own IF/ID register and evaluates the real branch outcome in ID. It then produces the BTB update bundle (update_en, branch_taken, resolved_pc, resolved_target, resolved_state) plus the front-end redirect/flush, and keeps branch and mispredict statistics.

---
 rtl/branch_resolve_unit_if.sv | 60 ++++++
 rtl/branch_resolve_unit.sv | 167 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit_if
//  Description : Bundle between the fetch/ID pipeline and the branch resolve
//                unit. It carries the fetch-side prediction metadata
//                (if_*), the ID-stage operands (stall, id_*), the BTB update
//                bundle, the front-end redirect and the statistics counters.
//                master : pipeline side, drives if_*/stall/id_*
//                slave  : branch_resolve_unit, drives update/redirect/counters
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    // Fetch-side prediction for the instruction entering IF/ID
    logic             if_valid;
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic [31:0]      if_pred_target;
    logic [1:0]       if_pred_state;

    // ID-stage operands
    logic             stall;
    logic             id_is_branch;
    logic             id_is_jal;
    logic [2:0]       id_funct3;
    logic [31:0]      id_rs1;
    logic [31:0]      id_rs2;
    logic [31:0]      id_imm;

    // BTB update bundle
    logic             update_en;
    logic             branch_taken;
    logic [31:0]      resolved_pc;
    logic [31:0]      resolved_target;
    logic [1:0]       resolved_state;

    // Front-end redirect
    logic             redirect_valid;
    logic [31:0]      redirect_pc;

    // Statistics
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output if_valid, if_pc, if_pred_taken, if_pred_target, if_pred_state,
        output stall, id_is_branch, id_is_jal, id_funct3, id_rs1, id_rs2, id_imm,
        input  update_en, branch_taken, resolved_pc, resolved_target, resolved_state,
        input  redirect_valid, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  if_valid, if_pc, if_pred_taken, if_pred_target, if_pred_state,
        input  stall, id_is_branch, id_is_jal, id_funct3, id_rs1, id_rs2, id_imm,
        output update_en, branch_taken, resolved_pc, resolved_target, resolved_state,
        output redirect_valid, redirect_pc, branch_count, mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : ID-stage branch resolution. Carries each fetched
//                instruction's prediction through a private IF/ID metadata
//                register, evaluates the real outcome in ID, emits the BTB
//                update bundle and the front-end redirect, and counts
//                resolved branches and redirects (saturating).
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - branch_resolve_unit_if.slave (fetch prediction in,
//                       ID operands in, update/redirect/counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    branch_resolve_unit_if.slave  bus
);

    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_bne  = 3'b001;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_bltu = 3'b110;
    localparam logic [2:0] c_f3_bgeu = 3'b111;

    // IF/ID prediction metadata
    logic             meta_valid_q, meta_valid_d;
    logic [31:0]      meta_pc_q,    meta_pc_d;
    logic             meta_pt_q,    meta_pt_d;
    logic [31:0]      meta_tgt_q,   meta_tgt_d;
    logic [1:0]       meta_st_q,    meta_st_d;

    logic [CNT_W-1:0] branch_count_q,     branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic             w_act;
    logic             w_eq;
    logic             w_slt;
    logic             w_ult;
    logic             w_cond;
    logic             w_taken;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic             w_update_en;
    logic             w_mispredict;
    logic             w_false_hit;
    logic             w_redirect_valid;
    logic [31:0]      w_redirect_pc;

    // ------------------------------------------------------------------
    // Resolution
    // ------------------------------------------------------------------
    always_comb begin
        w_eq  = (bus.id_rs1 == bus.id_rs2);
        w_slt = ($signed(bus.id_rs1) < $signed(bus.id_rs2));
        w_ult = (bus.id_rs1 < bus.id_rs2);

        w_cond = 1'b0;
        case (bus.id_funct3)
            c_f3_beq:  w_cond = w_eq;
            c_f3_bne:  w_cond = ~w_eq;
            c_f3_blt:  w_cond = w_slt;
            c_f3_bge:  w_cond = ~w_slt;
            c_f3_bltu: w_cond = w_ult;
            c_f3_bgeu: w_cond = ~w_ult;
            default:   w_cond = 1'b0;  // 010/011 are not branch conditions
        endcase

        // A JAL is always taken, whatever id_is_branch/funct3 say
        w_taken    = bus.id_is_jal | (bus.id_is_branch & w_cond);
        w_target   = meta_pc_q + bus.id_imm;
        w_pc_plus4 = meta_pc_q + 32'd4;

        // A stalled ID instruction must not resolve: it will be seen again
        w_act       = meta_valid_q & ~bus.stall;
        w_update_en = w_act & (bus.id_is_branch | bus.id_is_jal);

        w_mispredict = w_update_en &
                       ((w_taken != meta_pt_q) |
                        (w_taken & meta_pt_q & (w_target != meta_tgt_q)));

        // Predictor said "taken" for something that is not a control transfer
        w_false_hit = w_act & ~bus.id_is_branch & ~bus.id_is_jal & meta_pt_q;

        w_redirect_valid = w_mispredict | w_false_hit;

        w_redirect_pc = 32'd0;
        if (w_mispredict) begin
            w_redirect_pc = w_taken ? w_target : w_pc_plus4;
        end else if (w_false_hit) begin
            w_redirect_pc = w_pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        meta_valid_d       = meta_valid_q;
        meta_pc_d          = meta_pc_q;
        meta_pt_d          = meta_pt_q;
        meta_tgt_d         = meta_tgt_q;
        meta_st_d          = meta_st_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (bus.stall) begin
            // hold everything
        end else if (w_redirect_valid) begin
            // The instruction now in IF is on the wrong path
            meta_valid_d = 1'b0;
        end else begin
            meta_valid_d = bus.if_valid;
            meta_pc_d    = bus.if_pc;
            meta_pt_d    = bus.if_pred_taken;
            meta_tgt_d   = bus.if_pred_target;
            meta_st_d    = bus.if_pred_state;
        end

        if (w_update_en && (branch_count_q != {CNT_W{1'b1}})) begin
            branch_count_d = branch_count_q + 1'b1;
        end
        if (w_redirect_valid && (mispredict_count_q != {CNT_W{1'b1}})) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_valid_q       <= 1'b0;
            meta_pc_q          <= 32'd0;
            meta_pt_q          <= 1'b0;
            meta_tgt_q         <= 32'd0;
            meta_st_q          <= 2'd0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            meta_valid_q       <= meta_valid_d;
            meta_pc_q          <= meta_pc_d;
            meta_pt_q          <= meta_pt_d;
            meta_tgt_q         <= meta_tgt_d;
            meta_st_q          <= meta_st_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. branch_taken and resolved_target depend on live ID operands,
    // so they are forced low while reset is held to keep every output 0.
    // ------------------------------------------------------------------
    assign bus.update_en        = w_update_en;
    assign bus.branch_taken     = w_taken & ~rst;
    assign bus.resolved_pc      = meta_pc_q;
    assign bus.resolved_target  = rst ? 32'd0 : w_target;
    assign bus.resolved_state   = meta_st_q;
    assign bus.redirect_valid   = w_redirect_valid;
    assign bus.redirect_pc      = w_redirect_pc;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Directed self-checking bench for branch_resolve_unit.
//                Expected resolution bundles are queued when an instruction
//                is presented to ID and popped when the outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int CNT_W = 32;

    logic clk;
    logic rst;

    branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        upd;
        logic        tk;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  st;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_bc   = 0;
    int   exp_mc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_id();
        bus.stall        = 1'b0;
        bus.id_is_branch = 1'b0;
        bus.id_is_jal    = 1'b0;
        bus.id_funct3    = 3'd0;
        bus.id_rs1       = 32'd0;
        bus.id_rs2       = 32'd0;
        bus.id_imm       = 32'd0;
    endtask

    task automatic clear_if();
        bus.if_valid       = 1'b0;
        bus.if_pc          = 32'd0;
        bus.if_pred_taken  = 1'b0;
        bus.if_pred_target = 32'd0;
        bus.if_pred_state  = 2'd0;
    endtask

    // Present a prediction in IF; returns just after the loading edge with a
    // bubble behind it.
    task automatic fetch(input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptgt, input logic [1:0] st);
        @(negedge clk);
        bus.if_valid       = 1'b1;
        bus.if_pc          = pc;
        bus.if_pred_taken  = pt;
        bus.if_pred_target = ptgt;
        bus.if_pred_state  = st;
        @(posedge clk);
        #1;
        clear_if();
    endtask

    task automatic set_id(input logic br, input logic jal, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm);
        bus.id_is_branch = br;
        bus.id_is_jal    = jal;
        bus.id_funct3    = f3;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_imm       = imm;
    endtask

    task automatic push_exp(input logic upd, input logic tk, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic [1:0] st,
                            input logic rv, input logic [31:0] rpc);
        exp_t e;
        e = '{upd: upd, tk: tk, pc: pc, tgt: tgt, st: st, rv: rv, rpc: rpc};
        sb.push_back(e);
        if (upd) exp_bc++;
        if (rv)  exp_mc++;
    endtask

    task automatic check_pop();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("update_en",       bus.update_en,       e.upd);
            chk("branch_taken",    bus.branch_taken,    e.tk);
            chk("resolved_pc",     bus.resolved_pc,     e.pc);
            chk("resolved_target", bus.resolved_target, e.tgt);
            chk("resolved_state",  bus.resolved_state,  e.st);
            chk("redirect_valid",  bus.redirect_valid,  e.rv);
            chk("redirect_pc",     bus.redirect_pc,     e.rpc);
        end
    endtask

    task automatic tick_counts();
        @(posedge clk);
        #1;
        clear_id();
        chk("branch_count",     bus.branch_count,     exp_bc);
        chk("mispredict_count", bus.mispredict_count, exp_mc);
    endtask

    // One predicted instruction through IF -> ID with its expected bundle
    task automatic run_one(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                           input logic [1:0] st, input logic br, input logic jal,
                           input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm,
                           input logic upd, input logic tk, input logic [31:0] tgt,
                           input logic rv, input logic [31:0] rpc);
        fetch(pc, pt, ptgt, st);
        set_id(br, jal, f3, rs1, rs2, imm);
        push_exp(upd, tk, pc, tgt, st, rv, rpc);
        check_pop();
        tick_counts();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_if();
        clear_id();
        #12;
        chk("rst_update_en",       bus.update_en,        1'b0);
        chk("rst_redirect_valid",  bus.redirect_valid,   1'b0);
        chk("rst_redirect_pc",     bus.redirect_pc,      32'd0);
        chk("rst_resolved_pc",     bus.resolved_pc,      32'd0);
        chk("rst_resolved_target", bus.resolved_target,  32'd0);
        chk("rst_branch_count",    bus.branch_count,     32'd0);
        chk("rst_mispredict_count",bus.mispredict_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // BEQ taken, predicted NT: redirect to target; wrong-path fetch squashed
        fetch(32'h100, 1'b0, 32'h0, 2'b01);
        set_id(1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h40);
        bus.if_valid      = 1'b1;
        bus.if_pc         = 32'h104;
        bus.if_pred_taken = 1'b0;
        push_exp(1'b1, 1'b1, 32'h100, 32'h140, 2'b01, 1'b1, 32'h140);
        check_pop();
        @(posedge clk);
        #1;
        chk("t1_branch_count",     bus.branch_count,     exp_bc);
        chk("t1_mispredict_count", bus.mispredict_count, exp_mc);
        chk("t1_squash_update_en", bus.update_en,        1'b0);
        chk("t1_squash_redirect",  bus.redirect_valid,   1'b0);
        clear_if();
        clear_id();

        // BNE taken backwards, predicted correctly
        run_one(32'h200, 1'b1, 32'h1F8, 2'b11, 1'b1, 1'b0, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFF8,
                1'b1, 1'b1, 32'h1F8, 1'b0, 32'h0);
        // BLT signed: -1 < 1 taken, predicted NT
        run_one(32'h500, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20,
                1'b1, 1'b1, 32'h520, 1'b1, 32'h520);
        // BLTU: 0xFFFFFFFF < 1 false, predicted NT
        run_one(32'h600, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20,
                1'b1, 1'b0, 32'h620, 1'b0, 32'h0);
        // Predicted taken, wrong target
        run_one(32'h300, 1'b1, 32'h300, 2'b10, 1'b1, 1'b0, 3'b000, 32'd9, 32'd9, 32'h40,
                1'b1, 1'b1, 32'h340, 1'b1, 32'h340);
        // Non-branch predicted taken: false hit
        run_one(32'h400, 1'b1, 32'h480, 2'b11, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h10,
                1'b0, 1'b0, 32'h410, 1'b1, 32'h404);
        // JAL with branch flag and false condition: JAL wins, correct prediction
        run_one(32'h700, 1'b1, 32'h800, 2'b11, 1'b1, 1'b1, 3'b000, 32'd1, 32'd2, 32'h100,
                1'b1, 1'b1, 32'h800, 1'b0, 32'h0);
        // BGE 1 >= 2 false, predicted taken: redirect to fall-through
        run_one(32'h800, 1'b1, 32'h810, 2'b10, 1'b1, 1'b0, 3'b101, 32'd1, 32'd2, 32'h10,
                1'b1, 1'b0, 32'h810, 1'b1, 32'h804);
        // funct3 010 is never taken
        run_one(32'h900, 1'b0, 32'h0, 2'b01, 1'b1, 1'b0, 3'b010, 32'd3, 32'd3, 32'h4,
                1'b1, 1'b0, 32'h904, 1'b0, 32'h0);

        // Mispredicting BEQ held under stall for 3 cycles
        fetch(32'hA00, 1'b0, 32'h0, 2'b01);
        set_id(1'b1, 1'b0, 3'b000, 32'd7, 32'd7, 32'h40);
        bus.stall         = 1'b1;
        bus.if_valid      = 1'b1;
        bus.if_pc         = 32'hC00;
        bus.if_pred_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_update_en",   bus.update_en,      1'b0);
            chk("stall_redirect",    bus.redirect_valid, 1'b0);
            chk("stall_redirect_pc", bus.redirect_pc,    32'd0);
            chk("stall_resolved_pc", bus.resolved_pc,    32'hA00);
        end
        @(posedge clk);
        #1;
        chk("stall_branch_count",     bus.branch_count,     exp_bc);
        chk("stall_mispredict_count", bus.mispredict_count, exp_mc);
        bus.stall = 1'b0;
        clear_if();
        push_exp(1'b1, 1'b1, 32'hA00, 32'hA40, 2'b01, 1'b1, 32'hA40);
        check_pop();
        tick_counts();

        // Reset asserted in the middle of a stalled mispredicting branch
        fetch(32'hB00, 1'b0, 32'h0, 2'b01);
        set_id(1'b1, 1'b0, 3'b000, 32'd3, 32'd3, 32'h40);
        bus.stall = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_branch_count",     bus.branch_count,     32'd0);
        chk("mid_rst_mispredict_count", bus.mispredict_count, 32'd0);
        chk("mid_rst_update_en",        bus.update_en,        1'b0);
        chk("mid_rst_redirect_valid",   bus.redirect_valid,   1'b0);
        chk("mid_rst_redirect_pc",      bus.redirect_pc,      32'd0);
        chk("mid_rst_branch_taken",     bus.branch_taken,     1'b0);
        chk("mid_rst_resolved_pc",      bus.resolved_pc,      32'd0);
        chk("mid_rst_resolved_target",  bus.resolved_target,  32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_bc = 0;
        exp_mc = 0;
        bus.stall = 1'b0;
        @(negedge clk);
        chk("post_rst_update_en", bus.update_en,      1'b0);
        chk("post_rst_redirect",  bus.redirect_valid, 1'b0);
        tick_counts();

        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
